// File: rtl/uart_rx_frame_ctrl.sv
// Byte-stream framer for a UART receiver: SOF, LEN, payload, XOR checksum.
// Validated frames are held on a valid/ready port; framing errors pulse err_pulse.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_clear,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [3:0]  frm_len,
    output logic [63:0] frm_data,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [15:0] frm_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    localparam int             TW        = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  TMO_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0]  TMO_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    state_t         state_q, state_d;
    logic           clr_prev_q;
    logic [3:0]     len_q, len_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     xor_q, xor_d;
    logic [63:0]    data_q, data_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic [1:0]     code_q, code_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           valid_q;
    logic           accept_s;
    logic           tmo_hit_s;

    // A byte is taken only outside reset, never in OUT, and never right after a clear.
    assign accept_s  = rst & rx_ready & ~clr_prev_q & (state_q != ST_OUT);
    assign rx_clear  = accept_s;
    assign frm_valid = valid_q;
    assign frm_len   = len_q;
    assign frm_data  = data_q;
    assign err_pulse = err_q;
    assign err_code  = code_q;
    assign frm_cnt   = cnt_q;

    // Next-state logic: inter-byte timeout, frame parsing and output handshake.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        data_d    = data_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        code_d    = code_q;
        cnt_d     = cnt_q;
        tmo_hit_s = 1'b0;

        if ((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK)) begin
            if (accept_s) begin
                tmo_d = TMO_ZERO;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d     = TMO_ZERO;
                tmo_hit_s = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end else begin
            tmo_d = TMO_ZERO;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s && (rx_data == SOF)) begin
                    state_d = ST_LEN;
                    data_d  = 64'h0;
                    len_d   = 4'h0;
                    xor_d   = 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = rx_data[3:0];
                        xor_d   = rx_data;
                        idx_d   = 4'h0;
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_hit_s) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    data_d[{idx_q[2:0], 3'b000} +: 8] = rx_data;
                    xor_d = xor_q ^ rx_data;
                    idx_d = idx_q + 4'h1;
                    if (idx_q == (len_q - 4'h1)) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_hit_s) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    if (rx_data == xor_q) begin
                        state_d = ST_OUT;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_hit_s) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_OUT: begin
                if (frm_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + 16'h0001;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            clr_prev_q <= 1'b0;
            len_q      <= 4'h0;
            idx_q      <= 4'h0;
            xor_q      <= 8'h00;
            data_q     <= 64'h0;
            tmo_q      <= TMO_ZERO;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
            cnt_q      <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_prev_q <= accept_s;
            len_q      <= len_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            valid_q    <= (state_d == ST_OUT);
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames, randomized frame mix,
// timeout and mid-frame reset, checked against expectations built from the frame rules.
module tb_uart_rx_frame_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_clear;
    logic        frm_valid;
    logic        frm_ready;
    logic [3:0]  frm_len;
    logic [63:0] frm_data;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [15:0] frm_cnt;

    int          total = 0;
    int          bad = 0;
    int          clr_cnt = 0;
    int          b2b_cnt = 0;
    int          err_seen = 0;
    logic        clr_prev = 1'b0;
    logic [15:0] exp_cnt = 16'h0000;
    bit          use_gaps = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .SOF         (8'hA5),
        .MAX_LEN     (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_clear  (rx_clear),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_len   (frm_len),
        .frm_data  (frm_data),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .frm_cnt   (frm_cnt)
    );

    // Observe clear pulses, back-to-back clears and error pulses.
    always @(posedge clk) begin
        if (rx_clear) clr_cnt <= clr_cnt + 1;
        if (rx_clear && clr_prev) b2b_cnt <= b2b_cnt + 1;
        if (err_pulse) err_seen <= err_seen + 1;
        clr_prev <= rx_clear;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte (called at a negedge) until consumed; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        if (use_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (rx_clear === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL byte_accept: byte %0h observed=not consumed expected=consumed", b);
        end
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] pl [8], input bit with_sof,
                              input int hold, input bit sof_wait);
        logic [7:0]  chk;
        logic [63:0] exp_d;
        chk   = 8'(n);
        exp_d = 64'h0;
        for (int i = 0; i < n; i++) begin
            chk = chk ^ pl[i];
            exp_d[i*8 +: 8] = pl[i];
        end
        if (with_sof) send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) send_byte(pl[i]);
        send_byte(chk);
        check("frm_valid_latency", {63'h0, frm_valid}, 64'h1);
        check("frm_len", {60'h0, frm_len}, 64'(n));
        check("frm_data", frm_data, exp_d);
        check("no_err_on_good", {63'h0, err_pulse}, 64'h0);
        for (int h = 0; h < hold; h++) begin
            if (sof_wait) begin
                rx_ready = 1'b1;
                rx_data  = 8'hA5;
            end
            #1;
            check("hold_rx_clear", {63'h0, rx_clear}, 64'h0);
            check("hold_valid", {63'h0, frm_valid}, 64'h1);
            check("hold_data", frm_data, exp_d);
            @(negedge clk);
        end
        frm_ready = 1'b1;
        @(negedge clk);
        frm_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'h0001;
        check("valid_drop", {63'h0, frm_valid}, 64'h0);
        check("frm_cnt", {48'h0, frm_cnt}, {48'h0, exp_cnt});
        if (sof_wait) begin
            #1;
            check("clear_after_hs", {63'h0, rx_clear}, 64'h1);
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code, input int e0);
        check({tag, "_pulse"}, {63'h0, err_pulse}, 64'h1);
        check({tag, "_code"}, {62'h0, err_code}, {62'h0, code});
        check({tag, "_no_valid"}, {63'h0, frm_valid}, 64'h0);
        @(negedge clk);
        check({tag, "_pulse_len"}, {63'h0, err_pulse}, 64'h0);
        check({tag, "_pulse_once"}, 64'(err_seen - e0), 64'h1);
    endtask

    task automatic bad_chk_frame(input int n, input logic [7:0] pl [8], input logic [7:0] flip);
        logic [7:0] chk;
        int e0;
        e0  = err_seen;
        chk = 8'(n);
        for (int i = 0; i < n; i++) chk = chk ^ pl[i];
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) send_byte(pl[i]);
        send_byte(chk ^ flip);
        expect_err("bad_chk", 2'd2, e0);
    endtask

    task automatic bad_len_frame(input logic [7:0] l);
        int e0;
        e0 = err_seen;
        send_byte(8'hA5);
        send_byte(l);
        expect_err("bad_len", 2'd1, e0);
    endtask

    task automatic noise_byte(input logic [7:0] b);
        int c0;
        c0 = clr_cnt;
        send_byte(b);
        check("noise_cleared", 64'(clr_cnt - c0), 64'h1);
        check("noise_no_err", {63'h0, err_pulse}, 64'h0);
        check("noise_no_valid", {63'h0, frm_valid}, 64'h0);
    endtask

    logic [7:0] pl [8];
    int         c0;
    int         e0;
    int         n;
    int         waited;

    initial begin
        rst       = 1'b0;
        rx_ready  = 1'b1;
        rx_data   = 8'hA5;
        frm_ready = 1'b0;
        for (int i = 0; i < 8; i++) pl[i] = 8'h00;

        // Reset: byte waiting must not be taken, outputs at reset values.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_rx_clear", {63'h0, rx_clear}, 64'h0);
        end
        check("rst_valid", {63'h0, frm_valid}, 64'h0);
        check("rst_len", {60'h0, frm_len}, 64'h0);
        check("rst_data", frm_data, 64'h0);
        check("rst_err", {63'h0, err_pulse}, 64'h0);
        check("rst_code", {62'h0, err_code}, 64'h0);
        check("rst_cnt", {48'h0, frm_cnt}, 64'h0);
        rx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic 3-byte frame, six clear pulses.
        c0 = clr_cnt;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(3, pl, 1'b1, 0, 1'b0);
        check("six_clears", 64'(clr_cnt - c0), 64'd6);

        // Bad checksum.
        pl[0] = 8'h10; pl[1] = 8'h20;
        bad_chk_frame(2, pl, 8'h32);

        // Bad lengths, then a recovering frame.
        bad_len_frame(8'h00);
        bad_len_frame(8'h09);
        pl[0] = 8'h7E;
        send_frame(1, pl, 1'b1, 0, 1'b0);
        check("err_code_held", {62'h0, err_code}, 64'd1);

        // Noise dropped before a frame.
        noise_byte(8'h00);
        noise_byte(8'hFF);
        noise_byte(8'h5A);
        pl[0] = 8'h42;
        send_frame(1, pl, 1'b1, 0, 1'b0);

        // Backpressure with next SOF waiting; that SOF then starts the next frame.
        pl[0] = 8'hA5; pl[1] = 8'h01; pl[2] = 8'hFE; pl[3] = 8'h80;
        send_frame(4, pl, 1'b1, 10, 1'b1);
        pl[0] = 8'h5C; pl[1] = 8'hA5;
        send_frame(2, pl, 1'b0, 0, 1'b0);

        // Randomized mix of good, bad-checksum, bad-length and noise-prefixed frames.
        use_gaps = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) pl[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) pl[$urandom_range(0, n - 1)] = 8'hA5;
            case ($urandom_range(0, 3))
                0: send_frame(n, pl, 1'b1, $urandom_range(0, 3), 1'b0);
                1: bad_chk_frame(n, pl, 8'($urandom_range(1, 255)));
                2: bad_len_frame(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(9, 255)));
                default: begin
                    noise_byte((rx_data == 8'hA5) ? 8'h3C : 8'($urandom_range(0, 164)));
                    send_frame(n, pl, 1'b1, 0, 1'b0);
                end
            endcase
        end
        use_gaps = 1'b0;

        // Long gaps just under the timeout keep the frame alive.
        send_byte(8'hA5);
        repeat (TMO - 5) @(negedge clk);
        send_byte(8'h02);
        repeat (TMO - 5) @(negedge clk);
        send_byte(8'h11);
        repeat (TMO - 5) @(negedge clk);
        e0 = err_seen;
        pl[0] = 8'h22;
        send_byte(8'h22);
        repeat (TMO - 5) @(negedge clk);
        send_byte(8'h02 ^ 8'h11 ^ 8'h22);
        check("gap_no_err", 64'(err_seen - e0), 64'h0);
        check("gap_valid", {63'h0, frm_valid}, 64'h1);
        check("gap_data", frm_data, 64'h0000_0000_0000_2211);
        frm_ready = 1'b1;
        @(negedge clk);
        frm_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'h0001;
        check("gap_cnt", {48'h0, frm_cnt}, {48'h0, exp_cnt});

        // Inter-byte timeout.
        e0 = err_seen;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        waited = 0;
        while ((err_pulse !== 1'b1) && (waited < 2 * TMO + 10)) begin
            @(negedge clk);
            waited++;
        end
        total++;
        assert ((waited >= TMO - 1) && (waited <= TMO + 2)) else begin
            bad++;
            $error("FAIL timeout_delay: observed=%0d cycles expected=%0d", waited, TMO);
        end
        check("timeout_code", {62'h0, err_code}, 64'd3);
        check("timeout_no_valid", {63'h0, frm_valid}, 64'h0);
        @(negedge clk);
        check("timeout_pulse_once", 64'(err_seen - e0), 64'h1);

        // Mid-frame reset: partial frame discarded, no error, counters cleared.
        e0 = err_seen;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        rst      = 1'b0;
        rx_ready = 1'b1;
        rx_data  = 8'h22;
        #1;
        check("midrst_no_accept", {63'h0, rx_clear}, 64'h0);
        @(negedge clk);
        check("midrst_valid", {63'h0, frm_valid}, 64'h0);
        check("midrst_data", frm_data, 64'h0);
        check("midrst_len", {60'h0, frm_len}, 64'h0);
        check("midrst_code", {62'h0, err_code}, 64'h0);
        check("midrst_cnt", {48'h0, frm_cnt}, 64'h0);
        check("midrst_err", {63'h0, err_pulse}, 64'h0);
        rx_ready = 1'b0;
        rst      = 1'b1;
        exp_cnt  = 16'h0000;
        @(negedge clk);
        check("midrst_no_pulse", 64'(err_seen - e0), 64'h0);
        pl[0] = 8'h7E;
        send_frame(1, pl, 1'b1, 0, 1'b0);

        check("no_back_to_back_clear", 64'(b2b_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
